// File: rtl/flappy_pkg.sv
// Shared game-level types and constants for the pipe datapath.
//   game_state_t : top-level game FSM encoding (IDLE=0, PLAY=1, OVER=2)
//   SCREEN_W_PX / SCREEN_H_PX : visible raster size
//   LFSR_SEED    : reset value of the gap LFSR (any non-zero value works)
//   GAP_BASE     : lowest gap centre row, added to the 8-bit LFSR sample
//   SCORE_MAX    : score saturation point
//   half_gap()   : half opening height of a pipe pair for a given bird size
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int         SCREEN_W_PX = 640;
  localparam int         SCREEN_H_PX = 480;
  localparam logic [9:0] LFSR_SEED   = 10'h2A5;
  localparam int         GAP_BASE    = 112;
  localparam logic [9:0] SCORE_MAX   = 10'd999;

  function automatic int half_gap(input int bird_size);
    return 2 * bird_size;
  endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Bundle between the pipe scheduler and the game logic around it.
//   start, collide        : game controls into the scheduler
//   x, y0, y1             : per-slot pipe geometry, slot i at [i*N +: N]
//   active                : per-slot live flag
//   score, state, tick    : game status and scroll strobe
// master = the side driving start/collide, slave = the scheduler.
interface pipe_scheduler_if
  import flappy_pkg::*;
#(
  parameter int N         = 11,
  parameter int NUM_PIPES = 3
);
  logic                   start;
  logic                   collide;
  logic [NUM_PIPES*N-1:0] x;
  logic [NUM_PIPES*N-1:0] y0;
  logic [NUM_PIPES*N-1:0] y1;
  logic [NUM_PIPES-1:0]   active;
  logic [9:0]             score;
  game_state_t            state;
  logic                   tick;

  modport master (
    output start, collide,
    input  x, y0, y1, active, score, state, tick
  );

  modport slave (
    input  start, collide,
    output x, y0, y1, active, score, state, tick
  );
endinterface

// File: rtl/pipe_slot.sv
// One pipe slot: holds left edge x, gap edges y0/y1 and the live flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : game (re)start, drop the pipe and park x at SCREEN_W
//   step_i       : scroll tick accepted this cycle
//   load_i       : this slot was chosen for a spawn (only taken when free)
//   y0_i, y1_i   : gap edges for a spawned pipe
//   x_o, y0_o, y1_o, active_o : registered slot state
//   pass_o       : live pipe's trailing edge is at the bird's left edge
module pipe_slot #(
  parameter int N          = 11,
  parameter int SCREEN_W   = 640,
  parameter int PIPE_WIDTH = 40,
  parameter int BIRD_X     = 100
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [N-1:0] y0_i,
  input  logic [N-1:0] y1_i,
  output logic [N-1:0] x_o,
  output logic [N-1:0] y0_o,
  output logic [N-1:0] y1_o,
  output logic         active_o,
  output logic         pass_o
);
  localparam logic [N-1:0] PARK_X = N'(SCREEN_W);

  logic [N-1:0] x_q, y0_q, y1_q;
  logic         active_q;

  // A slot retiring on this tick is still active here, so it cannot take
  // the load in the same cycle; it becomes eligible on the following tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= PARK_X;
      y0_q     <= '0;
      y1_q     <= '0;
      active_q <= 1'b0;
    end else if (clear_i) begin
      x_q      <= PARK_X;
      active_q <= 1'b0;
    end else if (step_i) begin
      if (active_q) begin
        if (x_q == '0) begin
          active_q <= 1'b0;
          x_q      <= PARK_X;
        end else begin
          x_q <= x_q - N'(1);
        end
      end else if (load_i) begin
        active_q <= 1'b1;
        x_q      <= PARK_X;
        y0_q     <= y0_i;
        y1_q     <= y1_i;
      end
    end
  end

  assign x_o      = x_q;
  assign y0_o     = y0_q;
  assign y1_o     = y1_q;
  assign active_o = active_q;
  assign pass_o   = active_q && ((x_q + N'(PIPE_WIDTH)) == N'(BIRD_X));

endmodule

// File: rtl/pipe_scheduler.sv
// Game-level sequencer: game FSM, scroll-tick divider, gap LFSR, spawn
// selection over a pool of pipe slots, and score keeping.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pipe_scheduler_if (start/collide in; pipe
//             geometry, active flags, score, state and tick out)
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int N          = 11,
  parameter int NUM_PIPES  = 3,
  parameter int SCREEN_W   = SCREEN_W_PX,
  parameter int SPAWN_GAP  = 214,
  parameter int TICK_DIV   = 4166666,
  parameter int BIRD_X     = 100,
  parameter int PIPE_WIDTH = 40,
  parameter int BIRD_SIZE  = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_scheduler_if.slave  bus
);
  localparam int DIV_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int PC_W  = $clog2(NUM_PIPES + 1);
  localparam logic [N-1:0] HALF_N = N'(half_gap(BIRD_SIZE));
  localparam logic [N-1:0] BASE_N = N'(GAP_BASE);

  game_state_t      state_q;
  logic             tick_q;
  logic [DIV_W-1:0] div_q;
  logic [SP_W-1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [9:0]       score_q, score_d;
  logic [9:0]       lfsr_q, lfsr_d;

  logic [NUM_PIPES-1:0][N-1:0] x_w, y0_w, y1_w;
  logic [NUM_PIPES-1:0]        active_w, pass_w, load;
  logic                        free_found;
  logic [PC_W-1:0]             pass_cnt;
  logic [10:0]                 score_sum;
  logic [N-1:0]                gap_c, y0_new, y1_new;
  logic                        clear, step;

  // x^10 + x^7 + 1, shifting toward the MSB
  assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  assign clear = (state_q != PLAY) && bus.start;
  // collide on a tick cycle wins: the tick is dropped entirely
  assign step  = (state_q == PLAY) && tick_q && !bus.collide;

  assign gap_c  = BASE_N + N'(lfsr_q[7:0]);
  assign y0_new = gap_c + HALF_N;
  assign y1_new = gap_c - HALF_N;

  // Lowest-index free slot wins; only offered when the spawn counter is due.
  always_comb begin
    load       = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (!active_w[i] && !free_found) begin
        load[i]    = (spawn_cnt_q == '0);
        free_found = 1'b1;
      end
    end
  end

  // A due spawn with no free slot keeps the counter at zero so it fires
  // on the first tick that finds a slot.
  always_comb begin
    spawn_cnt_d = '0;
    if (spawn_cnt_q != '0) begin
      spawn_cnt_d = spawn_cnt_q - SP_W'(1);
    end else if (free_found) begin
      spawn_cnt_d = SP_W'(SPAWN_GAP - 1);
    end
  end

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pass_cnt = pass_cnt + PC_W'(pass_w[i]);
    end
    score_sum = {1'b0, score_q} + 11'(pass_cnt);
    score_d   = (score_sum > 11'(SCORE_MAX)) ? SCORE_MAX : score_sum[9:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= 1'b0;
      div_q       <= '0;
      spawn_cnt_q <= '0;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE, OVER: begin
          tick_q <= 1'b0;
          if (bus.start) begin
            state_q     <= PLAY;
            div_q       <= '0;
            spawn_cnt_q <= '0;
            score_q     <= '0;
          end
        end
        PLAY: begin
          if (bus.collide) begin
            state_q <= OVER;
            tick_q  <= 1'b0;
          end else begin
            if (div_q == DIV_W'(TICK_DIV - 1)) begin
              div_q  <= '0;
              tick_q <= 1'b1;
            end else begin
              div_q  <= div_q + DIV_W'(1);
              tick_q <= 1'b0;
            end
            if (tick_q) begin
              score_q     <= score_d;
              spawn_cnt_q <= spawn_cnt_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
    pipe_slot #(
      .N         (N),
      .SCREEN_W  (SCREEN_W),
      .PIPE_WIDTH(PIPE_WIDTH),
      .BIRD_X    (BIRD_X)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (clear),
      .step_i  (step),
      .load_i  (load[gi]),
      .y0_i    (y0_new),
      .y1_i    (y1_new),
      .x_o     (x_w[gi]),
      .y0_o    (y0_w[gi]),
      .y1_o    (y1_w[gi]),
      .active_o(active_w[gi]),
      .pass_o  (pass_w[gi])
    );
  end

  assign bus.x      = x_w;
  assign bus.y0     = y0_w;
  assign bus.y1     = y1_w;
  assign bus.active = active_w;
  assign bus.score  = score_q;
  assign bus.state  = state_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
module tb_pipe_scheduler;
  localparam int TD = 4;
  localparam int SW = 20;
  localparam int BX = 10;
  localparam int PW = 4;
  localparam int BS = 15;
  localparam int NP = 3;
  localparam int NB = 11;
  int GAP [2] = '{8, 3};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic collide = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_scheduler_if #(.N(NB), .NUM_PIPES(NP)) sif_a ();
  pipe_scheduler_if #(.N(NB), .NUM_PIPES(NP)) sif_b ();
  assign sif_a.start = start;
  assign sif_a.collide = collide;
  assign sif_b.start = start;
  assign sif_b.collide = collide;

  pipe_scheduler #(.N(NB), .NUM_PIPES(NP), .SCREEN_W(SW), .SPAWN_GAP(8), .TICK_DIV(TD),
                   .BIRD_X(BX), .PIPE_WIDTH(PW), .BIRD_SIZE(BS))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(sif_a));
  pipe_scheduler #(.N(NB), .NUM_PIPES(NP), .SCREEN_W(SW), .SPAWN_GAP(3), .TICK_DIV(TD),
                   .BIRD_X(BX), .PIPE_WIDTH(PW), .BIRD_SIZE(BS))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(sif_b));

  // ---------------- reference model (one per DUT) ----------------
  // state: 0 idle, 1 play, 2 over; cyc = clock edges spent in play
  int m_state[2], m_cyc[2], m_score[2], m_scnt[2], m_lfsr[2];
  int m_x[2][NP], m_y0[2][NP], m_y1[2][NP];
  bit m_act[2][NP];

  function automatic bit m_tick(input int d);
    return (m_state[d] == 1) && (m_cyc[d] > 0) && (m_cyc[d] % TD == 0);
  endfunction

  task automatic model_reset(input int d);
    m_state[d] = 0; m_cyc[d] = 0; m_score[d] = 0; m_scnt[d] = 0; m_lfsr[d] = 'h2A5;
    for (int i = 0; i < NP; i++) begin
      m_x[d][i] = SW; m_y0[d][i] = 0; m_y1[d][i] = 0; m_act[d][i] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit st, input bit co);
    int free_idx, passes, c;
    if (m_state[d] != 1) begin
      if (st) begin
        m_state[d] = 1; m_cyc[d] = 0; m_score[d] = 0; m_scnt[d] = 0;
        for (int i = 0; i < NP; i++) begin m_act[d][i] = 0; m_x[d][i] = SW; end
      end
    end else if (co) begin
      m_state[d] = 2;
    end else begin
      if (m_tick(d)) begin
        free_idx = -1;
        for (int i = 0; i < NP; i++) if (!m_act[d][i] && free_idx < 0) free_idx = i;
        passes = 0;
        for (int i = 0; i < NP; i++) begin
          if (m_act[d][i]) begin
            if (m_x[d][i] + PW == BX) passes++;
            if (m_x[d][i] == 0) begin m_act[d][i] = 0; m_x[d][i] = SW; end
            else m_x[d][i] = m_x[d][i] - 1;
          end
        end
        m_score[d] = (m_score[d] + passes > 999) ? 999 : m_score[d] + passes;
        if (m_scnt[d] == 0) begin
          if (free_idx >= 0) begin
            c = 112 + (m_lfsr[d] & 'hFF);
            m_act[d][free_idx] = 1; m_x[d][free_idx] = SW;
            m_y0[d][free_idx] = c + 2 * BS; m_y1[d][free_idx] = c - 2 * BS;
            m_scnt[d] = GAP[d] - 1;
          end
        end else begin
          m_scnt[d] = m_scnt[d] - 1;
        end
      end
      m_cyc[d]++;
    end
    m_lfsr[d] = ((m_lfsr[d] << 1) & 'h3FF) | (((m_lfsr[d] >> 9) ^ (m_lfsr[d] >> 6)) & 1);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge reset_n);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) model_reset(d);
        else model_step(d, start, collide);
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic stop_if_flooded();
    if (errors >= 30) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
      stop_if_flooded();
    end
  endtask

  task automatic check_dut(input int d);
    logic [NP*NB-1:0] gx, gy0, gy1, ex, ey0, ey1;
    logic [NP-1:0] ga, ea;
    logic [9:0] gs;
    int gst;
    logic gt;
    if (d == 0) begin
      gx = sif_a.x; gy0 = sif_a.y0; gy1 = sif_a.y1; ga = sif_a.active;
      gs = sif_a.score; gst = int'(sif_a.state); gt = sif_a.tick;
    end else begin
      gx = sif_b.x; gy0 = sif_b.y0; gy1 = sif_b.y1; ga = sif_b.active;
      gs = sif_b.score; gst = int'(sif_b.state); gt = sif_b.tick;
    end
    for (int i = 0; i < NP; i++) begin
      ex[i*NB +: NB] = NB'(m_x[d][i]);
      ey0[i*NB +: NB] = NB'(m_y0[d][i]);
      ey1[i*NB +: NB] = NB'(m_y1[d][i]);
      ea[i] = m_act[d][i];
    end
    checks++;
    if (gx !== ex || gy0 !== ey0 || gy1 !== ey1 || ga !== ea || gs !== 10'(m_score[d]) ||
        gst !== m_state[d] || gt !== m_tick(d)) begin
      errors++;
      $display("FAIL model_dut%0d t=%0t state %0d/%0d tick %b/%b act %b/%b score %0d/%0d x %h/%h y0 %h/%h y1 %h/%h (got/exp)",
               d, $time, gst, m_state[d], gt, m_tick(d), ga, ea, gs, m_score[d], gx, ex, gy0, ey0, gy1, ey1);
      stop_if_flooded();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_dut(0);
      check_dut(1);
    end
  end

  task automatic clk1();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int st; int co; int n;
    int e_state; int e_act; int e_x0; int e_tick;
  } vec_t;

  vec_t tbl[15];
  int n;

  initial begin
    tbl[0]  = '{0, 0, 2,  0, 3'b000, 20, 0};  // idle after reset
    tbl[1]  = '{1, 0, 1,  1, 3'b000, 20, 0};  // start -> play next clk
    tbl[2]  = '{0, 0, 3,  1, 3'b000, 20, 0};
    tbl[3]  = '{0, 0, 1,  1, 3'b000, 20, 1};  // first tick 4 clks in
    tbl[4]  = '{0, 0, 1,  1, 3'b001, 20, 0};  // slot0 spawned
    tbl[5]  = '{0, 0, 4,  1, 3'b001, 19, 0};
    tbl[6]  = '{0, 0, 24, 1, 3'b001, 13, 0};  // after 8 ticks
    tbl[7]  = '{0, 0, 4,  1, 3'b011, 12, 0};  // slot1 spawns on 9th tick
    tbl[8]  = '{0, 0, 3,  1, 3'b011, 12, 1};  // tick visible
    tbl[9]  = '{0, 1, 1,  2, 3'b011, 12, 0};  // collide on tick: no move
    tbl[10] = '{0, 0, 5,  2, 3'b011, 12, 0};  // over freezes
    tbl[11] = '{0, 1, 2,  2, 3'b011, 12, 0};  // collide ignored in over
    tbl[12] = '{1, 0, 1,  1, 3'b000, 20, 0};  // restart clears
    tbl[13] = '{1, 0, 6,  1, 3'b001, 20, 0};  // start held: no effect
    tbl[14] = '{0, 0, 4,  1, 3'b001, 19, 0};

    repeat (3) clk1();
    reset_n = 1'b1;
    for (int r = 0; r < 15; r++) begin
      start = tbl[r].st[0];
      collide = tbl[r].co[0];
      repeat (tbl[r].n) clk1();
      checks++;
      if (int'(sif_a.state) !== tbl[r].e_state || int'(sif_a.active) !== tbl[r].e_act ||
          int'(sif_a.x[NB-1:0]) !== tbl[r].e_x0 || int'(sif_a.tick) !== tbl[r].e_tick ||
          sif_a.score !== 10'd0) begin
        errors++;
        $display("FAIL vec%0d: state %0d act %b x0 %0d tick %b score %0d, expected state %0d act %b x0 %0d tick %0d score 0",
                 r, sif_a.state, sif_a.active, sif_a.x[NB-1:0], sif_a.tick, sif_a.score,
                 tbl[r].e_state, tbl[r].e_act[2:0], tbl[r].e_x0, tbl[r].e_tick);
        stop_if_flooded();
      end
    end
    start = 1'b0;
    collide = 1'b0;

    // fresh game: scoring instant on A, spawn deferral on B
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b1;
    clk1();
    start = 1'b0;
    repeat (61) clk1();
    expect_int("score_before_pass", sif_a.score, 0);
    repeat (4) clk1();
    expect_int("score_on_pass", sif_a.score, 1);
    repeat (24) clk1();
    expect_int("defer_slot0_freed", sif_b.active, 3'b110);
    repeat (4) clk1();
    expect_int("defer_respawn_active", sif_b.active, 3'b111);
    expect_int("defer_respawn_x0", sif_b.x[NB-1:0], SW);

    // long run to score saturation
    n = 0;
    while (sif_a.score != 10'd999 && n < 40000) begin
      clk1();
      n++;
    end
    expect_int("score_reach_999", sif_a.score, 999);
    repeat (400) clk1();
    expect_int("score_hold_999", sif_a.score, 999);
    expect_int("still_play", sif_a.state, 1);

    // asynchronous reset mid-play takes effect without a clock edge
    reset_n = 1'b0;
    #1;
    expect_int("rst_state", sif_a.state, 0);
    expect_int("rst_active", sif_a.active, 0);
    expect_int("rst_score", sif_a.score, 0);
    expect_int("rst_tick", sif_a.tick, 0);
    checks++;
    if (sif_a.x !== {NP{11'd20}}) begin
      errors++;
      $display("FAIL rst_x: got %h expected %h", sif_a.x, {NP{11'd20}});
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    // random play, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      collide = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
      end
      clk1();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
